// File: rtl/serial_lane_arbiter_pkg.sv
// serial_arb_pkg
//   Shared definitions for the serial lane arbiter: arbiter FSM state
//   encoding, response status codes, decoder data width and the saturating
//   increment used by the error counter.
package serial_arb_pkg;

  // Decoder parallel output width
  localparam int DATA_W = 8;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DONE  = 2'd2,
    ABORT = 2'd3
  } state_t;

  // Response status codes
  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_CKSUM   = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam logic [1:0] ST_CANCEL  = 2'b11;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] value);
    logic [DATA_W-1:0] result;
    if (value == {DATA_W{1'b1}}) begin
      result = value;
    end else begin
      result = value + {{(DATA_W-1){1'b0}}, 1'b1};
    end
    return result;
  endfunction

endpackage

// File: rtl/serial_lane_arbiter_rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin picker. Searches the request vector starting
//   at rr_ptr and wrapping, and returns a one-hot grant for the first
//   requesting lane found.
// Ports
//   req        in   LANES   per-lane request
//   rr_ptr     in   LANE_W  lane with highest priority this round
//   grant_next out  LANES   one-hot grant (all zero when no request)
//   any        out  1       at least one lane is requesting
module rr_arbiter #(
  parameter int LANES = 4,
  localparam int LANE_W = $clog2(LANES)
) (
  input  logic [LANES-1:0]  req,
  input  logic [LANE_W-1:0] rr_ptr,
  output logic [LANES-1:0]  grant_next,
  output logic              any
);

  logic [LANE_W-1:0] idx_s;
  logic              found_s;

  // Walk lanes in priority order from rr_ptr, granting the first requester
  always_comb begin
    grant_next = '0;
    found_s    = 1'b0;
    idx_s      = '0;
    for (int i = 0; i < LANES; i++) begin
      idx_s = LANE_W'((int'(rr_ptr) + i) % LANES);
      if (!found_s && req[idx_s]) begin
        grant_next[idx_s] = 1'b1;
        found_s           = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
    any = |req;
  end

endmodule

// File: rtl/serial_lane_arbiter.sv
// serial_lane_arbiter
//   Shares one serial protocol decoder between LANES serial requesters.
//   One lane is granted per frame in round-robin order; its serial line is
//   muxed onto the decoder input, and the decoder's valid/error pulse is
//   returned as a lane-tagged response. Frames that stall past TIMEOUT
//   cycles, or whose requester withdraws, are aborted and the decoder is
//   flushed with a one-cycle dec_abort pulse.
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   req             per-lane frame request, held until that lane's rsp
//   lane_serial     per-lane serial lines (idle high)
//   gnt             one-hot grant
//   dec_serial_in   granted lane's line while BUSY, else 1
//   dec_abort       one-cycle decoder flush pulse
//   dec_valid       decoder frame-good pulse
//   dec_error       decoder checksum-error pulse
//   dec_data        decoder byte, sampled with dec_valid
//   rsp_valid       one-cycle response pulse
//   rsp_lane        lane the response belongs to
//   rsp_data        captured byte (0 unless status OK)
//   rsp_status      OK / CHECKSUM_ERR / TIMEOUT / CANCELLED
//   busy            a lane is currently granted
//   err_count       saturating count of non-OK responses
module serial_lane_arbiter
  import serial_arb_pkg::*;
#(
  parameter int LANES   = 4,
  parameter int TIMEOUT = 32,
  localparam int LANE_W = $clog2(LANES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [LANES-1:0]  req,
  input  logic [LANES-1:0]  lane_serial,
  output logic [LANES-1:0]  gnt,
  output logic              dec_serial_in,
  output logic              dec_abort,
  input  logic              dec_valid,
  input  logic              dec_error,
  input  logic [DATA_W-1:0] dec_data,
  output logic              rsp_valid,
  output logic [LANE_W-1:0] rsp_lane,
  output logic [DATA_W-1:0] rsp_data,
  output logic [1:0]        rsp_status,
  output logic              busy,
  output logic [7:0]        err_count
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state_r;
  logic [LANES-1:0]  gnt_r;
  logic [LANE_W-1:0] lane_r;
  logic [LANE_W-1:0] rr_ptr_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              rsp_valid_r;
  logic [LANE_W-1:0] rsp_lane_r;
  logic [DATA_W-1:0] rsp_data_r;
  logic [1:0]        rsp_status_r;
  logic              dec_abort_r;
  logic              busy_r;
  logic [7:0]        err_count_r;

  logic [LANES-1:0]  grant_next_s;
  logic              any_s;
  logic [LANE_W-1:0] pick_idx_s;
  logic              end_s;
  logic              end_abort_s;
  logic [1:0]        end_status_s;
  logic [DATA_W-1:0] end_data_s;
  logic [LANE_W-1:0] rr_next_s;

  rr_arbiter #(.LANES(LANES)) u_rr (
    .req        (req),
    .rr_ptr     (rr_ptr_r),
    .grant_next (grant_next_s),
    .any        (any_s)
  );

  // Convert the one-hot pick into the lane index used by the mux and rsp_lane
  always_comb begin
    pick_idx_s = '0;
    for (int j = 0; j < LANES; j++) begin
      pick_idx_s = grant_next_s[j] ? LANE_W'(j) : pick_idx_s;
    end
  end

  // Frame-ending events while BUSY, in priority order error > valid > cancel > timeout
  always_comb begin
    end_s        = 1'b0;
    end_abort_s  = 1'b0;
    end_status_s = ST_OK;
    end_data_s   = '0;
    if (dec_error) begin
      end_s        = 1'b1;
      end_status_s = ST_CKSUM;
    end else if (dec_valid) begin
      end_s        = 1'b1;
      end_status_s = ST_OK;
      end_data_s   = dec_data;
    end else if (!req[lane_r]) begin
      end_s        = 1'b1;
      end_abort_s  = 1'b1;
      end_status_s = ST_CANCEL;
    end else if (cnt_r == CNT_LAST) begin
      end_s        = 1'b1;
      end_abort_s  = 1'b1;
      end_status_s = ST_TIMEOUT;
    end else begin
      end_s = 1'b0;
    end
  end

  // Round-robin pointer moves to the lane after the one just served
  always_comb begin
    if (lane_r == LANE_W'(LANES - 1)) begin
      rr_next_s = '0;
    end else begin
      rr_next_s = lane_r + LANE_W'(1);
    end
  end

  // Arbiter FSM with timeout counter and registered response outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      gnt_r        <= '0;
      lane_r       <= '0;
      rr_ptr_r     <= '0;
      cnt_r        <= '0;
      rsp_valid_r  <= 1'b0;
      rsp_lane_r   <= '0;
      rsp_data_r   <= '0;
      rsp_status_r <= ST_OK;
      dec_abort_r  <= 1'b0;
      busy_r       <= 1'b0;
      err_count_r  <= '0;
    end else begin
      // Pulse outputs default low; rsp_lane/data/status hold between pulses
      rsp_valid_r <= 1'b0;
      dec_abort_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (any_s) begin
            gnt_r   <= grant_next_s;
            lane_r  <= pick_idx_s;
            busy_r  <= 1'b1;
            cnt_r   <= '0;
            state_r <= BUSY;
          end else begin
            state_r <= IDLE;
          end
        end
        BUSY: begin
          if (end_s) begin
            gnt_r        <= '0;
            busy_r       <= 1'b0;
            rsp_valid_r  <= 1'b1;
            rsp_lane_r   <= lane_r;
            rsp_data_r   <= end_data_s;
            rsp_status_r <= end_status_s;
            dec_abort_r  <= end_abort_s;
            rr_ptr_r     <= rr_next_s;
            if (end_status_s != ST_OK) begin
              err_count_r <= sat_inc(err_count_r);
            end else begin
              err_count_r <= err_count_r;
            end
            state_r <= end_abort_s ? ABORT : DONE;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        ABORT: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          gnt_r   <= '0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // The decoder only sees a lane's line while that lane's frame is active
  assign dec_serial_in = (state_r == BUSY) ? lane_serial[lane_r] : 1'b1;

  assign gnt        = gnt_r;
  assign dec_abort  = dec_abort_r;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_lane   = rsp_lane_r;
  assign rsp_data   = rsp_data_r;
  assign rsp_status = rsp_status_r;
  assign busy       = busy_r;
  assign err_count  = err_count_r;

endmodule

// File: tb/tb_serial_lane_arbiter.sv
// tb_serial_lane_arbiter
//   Directed bench for serial_lane_arbiter (LANES=4, TIMEOUT=32). The bench
//   plays the role of the decoder by driving dec_valid/dec_error/dec_data.
//   A per-cycle vector table covers fairness, single-lane, checksum, cancel,
//   event coincidence and stray pulses; hand sequences cover timeout,
//   asynchronous reset mid-frame and err_count saturation.
module tb_serial_lane_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] lane_serial = 4'b1111;
  logic [3:0] gnt;
  logic       dec_serial_in;
  logic       dec_abort;
  logic       dec_valid = 1'b0;
  logic       dec_error = 1'b0;
  logic [7:0] dec_data = 8'h00;
  logic       rsp_valid;
  logic [1:0] rsp_lane;
  logic [7:0] rsp_data;
  logic [1:0] rsp_status;
  logic       busy;
  logic [7:0] err_count;

  int checks = 0;
  int errors = 0;

  serial_lane_arbiter #(.LANES(4), .TIMEOUT(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req           (req),
    .lane_serial   (lane_serial),
    .gnt           (gnt),
    .dec_serial_in (dec_serial_in),
    .dec_abort     (dec_abort),
    .dec_valid     (dec_valid),
    .dec_error     (dec_error),
    .dec_data      (dec_data),
    .rsp_valid     (rsp_valid),
    .rsp_lane      (rsp_lane),
    .rsp_data      (rsp_data),
    .rsp_status    (rsp_status),
    .busy          (busy),
    .err_count     (err_count)
  );

  always #5 clk = ~clk;

  // Inputs applied before the edge, expected outputs sampled 1 time unit after it
  typedef struct packed {
    logic [3:0] req;
    logic [3:0] ser;
    logic       dv;
    logic       de;
    logic [7:0] dd;
    logic [3:0] gnt;
    logic       busy;
    logic       rv;
    logic [1:0] rl;
    logic [7:0] rd;
    logic [1:0] rs;
    logic       ab;
    logic [7:0] ec;
    logic       dsi;
  } vec_t;

  vec_t tbl [0:33];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [27:0] outs();
    return {gnt, busy, rsp_valid, rsp_lane, rsp_data, rsp_status, dec_abort, err_count, dec_serial_in};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    logic seen;

    //                req    ser    dv    de    dd      gnt     busy  rv    rl    rd      rs    ab    ec     dsi
    tbl[0]  = '{4'hF, 4'hA, 1'b0, 1'b0, 8'h00, 4'b0001, 1'b1, 1'b0, 2'd0, 8'h00, 2'd0, 1'b0, 8'd0, 1'b0};
    tbl[1]  = '{4'hF, 4'hA, 1'b1, 1'b0, 8'h11, 4'b0000, 1'b0, 1'b1, 2'd0, 8'h11, 2'd0, 1'b0, 8'd0, 1'b1};
    tbl[2]  = '{4'hF, 4'hA, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0, 2'd0, 8'h11, 2'd0, 1'b0, 8'd0, 1'b1};
    tbl[3]  = '{4'hF, 4'hA, 1'b0, 1'b0, 8'h00, 4'b0010, 1'b1, 1'b0, 2'd0, 8'h11, 2'd0, 1'b0, 8'd0, 1'b1};
    tbl[4]  = '{4'hF, 4'hA, 1'b1, 1'b0, 8'h22, 4'b0000, 1'b0, 1'b1, 2'd1, 8'h22, 2'd0, 1'b0, 8'd0, 1'b1};
    tbl[5]  = '{4'hF, 4'hA, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0, 2'd1, 8'h22, 2'd0, 1'b0, 8'd0, 1'b1};
    tbl[6]  = '{4'hF, 4'hA, 1'b0, 1'b0, 8'h00, 4'b0100, 1'b1, 1'b0, 2'd1, 8'h22, 2'd0, 1'b0, 8'd0, 1'b0};
    tbl[7]  = '{4'hF, 4'hA, 1'b1, 1'b0, 8'h33, 4'b0000, 1'b0, 1'b1, 2'd2, 8'h33, 2'd0, 1'b0, 8'd0, 1'b1};
    tbl[8]  = '{4'hF, 4'hA, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0, 2'd2, 8'h33, 2'd0, 1'b0, 8'd0, 1'b1};
    tbl[9]  = '{4'hF, 4'hA, 1'b0, 1'b0, 8'h00, 4'b1000, 1'b1, 1'b0, 2'd2, 8'h33, 2'd0, 1'b0, 8'd0, 1'b1};
    tbl[10] = '{4'hF, 4'hA, 1'b1, 1'b0, 8'h44, 4'b0000, 1'b0, 1'b1, 2'd3, 8'h44, 2'd0, 1'b0, 8'd0, 1'b1};
    tbl[11] = '{4'hF, 4'hA, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0, 2'd3, 8'h44, 2'd0, 1'b0, 8'd0, 1'b1};
    tbl[12] = '{4'hF, 4'hA, 1'b0, 1'b0, 8'h00, 4'b0001, 1'b1, 1'b0, 2'd3, 8'h44, 2'd0, 1'b0, 8'd0, 1'b0};
    tbl[13] = '{4'hF, 4'hA, 1'b1, 1'b0, 8'h55, 4'b0000, 1'b0, 1'b1, 2'd0, 8'h55, 2'd0, 1'b0, 8'd0, 1'b1};
    tbl[14] = '{4'h0, 4'hF, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0, 2'd0, 8'h55, 2'd0, 1'b0, 8'd0, 1'b1};
    // single lane 2, byte A5, good frame
    tbl[15] = '{4'h4, 4'hF, 1'b0, 1'b0, 8'h00, 4'b0100, 1'b1, 1'b0, 2'd0, 8'h55, 2'd0, 1'b0, 8'd0, 1'b1};
    tbl[16] = '{4'h4, 4'hB, 1'b0, 1'b0, 8'h00, 4'b0100, 1'b1, 1'b0, 2'd0, 8'h55, 2'd0, 1'b0, 8'd0, 1'b0};
    tbl[17] = '{4'h4, 4'hF, 1'b1, 1'b0, 8'hA5, 4'b0000, 1'b0, 1'b1, 2'd2, 8'hA5, 2'd0, 1'b0, 8'd0, 1'b1};
    tbl[18] = '{4'h0, 4'hF, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0, 2'd2, 8'hA5, 2'd0, 1'b0, 8'd0, 1'b1};
    // lane 1 checksum error, data forced to 0
    tbl[19] = '{4'h2, 4'hF, 1'b0, 1'b0, 8'h00, 4'b0010, 1'b1, 1'b0, 2'd2, 8'hA5, 2'd0, 1'b0, 8'd0, 1'b1};
    tbl[20] = '{4'h2, 4'hD, 1'b0, 1'b0, 8'h00, 4'b0010, 1'b1, 1'b0, 2'd2, 8'hA5, 2'd0, 1'b0, 8'd0, 1'b0};
    tbl[21] = '{4'h2, 4'hF, 1'b0, 1'b1, 8'h3C, 4'b0000, 1'b0, 1'b1, 2'd1, 8'h00, 2'd1, 1'b0, 8'd1, 1'b1};
    tbl[22] = '{4'h0, 4'hF, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0, 2'd1, 8'h00, 2'd1, 1'b0, 8'd1, 1'b1};
    // lane 0 cancels mid-frame
    tbl[23] = '{4'h1, 4'hF, 1'b0, 1'b0, 8'h00, 4'b0001, 1'b1, 1'b0, 2'd1, 8'h00, 2'd1, 1'b0, 8'd1, 1'b1};
    tbl[24] = '{4'h1, 4'hE, 1'b0, 1'b0, 8'h00, 4'b0001, 1'b1, 1'b0, 2'd1, 8'h00, 2'd1, 1'b0, 8'd1, 1'b0};
    tbl[25] = '{4'h0, 4'hF, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b1, 2'd0, 8'h00, 2'd3, 1'b1, 8'd2, 1'b1};
    tbl[26] = '{4'h0, 4'hF, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0, 2'd0, 8'h00, 2'd3, 1'b0, 8'd2, 1'b1};
    // lane 3: valid and error together -> checksum error wins
    tbl[27] = '{4'h8, 4'hF, 1'b0, 1'b0, 8'h00, 4'b1000, 1'b1, 1'b0, 2'd0, 8'h00, 2'd3, 1'b0, 8'd2, 1'b1};
    tbl[28] = '{4'h8, 4'hF, 1'b1, 1'b1, 8'h77, 4'b0000, 1'b0, 1'b1, 2'd3, 8'h00, 2'd1, 1'b0, 8'd3, 1'b1};
    // stray decoder pulses in DONE and IDLE are ignored
    tbl[29] = '{4'h0, 4'hF, 1'b1, 1'b0, 8'h99, 4'b0000, 1'b0, 1'b0, 2'd3, 8'h00, 2'd1, 1'b0, 8'd3, 1'b1};
    tbl[30] = '{4'h0, 4'hF, 1'b1, 1'b0, 8'h99, 4'b0000, 1'b0, 1'b0, 2'd3, 8'h00, 2'd1, 1'b0, 8'd3, 1'b1};
    // lane 2: valid coincides with cancel -> OK wins
    tbl[31] = '{4'h4, 4'hF, 1'b0, 1'b0, 8'h00, 4'b0100, 1'b1, 1'b0, 2'd3, 8'h00, 2'd1, 1'b0, 8'd3, 1'b1};
    tbl[32] = '{4'h0, 4'hF, 1'b1, 1'b0, 8'h5A, 4'b0000, 1'b0, 1'b1, 2'd2, 8'h5A, 2'd0, 1'b0, 8'd3, 1'b1};
    tbl[33] = '{4'h0, 4'hF, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0, 2'd2, 8'h5A, 2'd0, 1'b0, 8'd3, 1'b1};

    // Reset state
    cyc();
    cyc();
    chk("reset_state", outs(), 28'd1);
    rst_n = 1'b1;
    cyc();
    chk("idle_after_reset", outs(), 28'd1);

    // Vector table
    for (int i = 0; i < 34; i++) begin
      req         = tbl[i].req;
      lane_serial = tbl[i].ser;
      dec_valid   = tbl[i].dv;
      dec_error   = tbl[i].de;
      dec_data    = tbl[i].dd;
      cyc();
      chk($sformatf("vec%0d", i), outs(), tbl[i][27:0]);
    end
    dec_valid = 1'b0;
    dec_error = 1'b0;
    dec_data  = 8'h00;

    // Timeout: lane 3 holds its line high, lane 0 waits behind it
    req         = 4'b1001;
    lane_serial = 4'b1111;
    cyc();
    chk("to_grant", gnt, 4'b1000);
    n = 0;
    while (!dec_abort && n < 100) begin
      cyc();
      n++;
    end
    chk("to_cycles", n, 32);
    chk("to_rsp", {rsp_valid, rsp_lane, rsp_data, rsp_status, err_count, gnt, busy},
        {1'b1, 2'd3, 8'h00, 2'd2, 8'd4, 4'b0000, 1'b0});
    req = 4'b0001;
    cyc();
    chk("to_abort_once", {dec_abort, rsp_valid}, 2'b00);
    cyc();
    chk("to_next_gnt", gnt, 4'b0001);
    dec_valid = 1'b1;
    dec_data  = 8'hC3;
    cyc();
    dec_valid = 1'b0;
    req       = 4'b0000;
    chk("to_next_rsp", {rsp_valid, rsp_lane, rsp_data, rsp_status}, {1'b1, 2'd0, 8'hC3, 2'd0});
    cyc();

    // Reset in the middle of lane 1's frame
    req = 4'b0010;
    cyc();
    chk("rst_pre_gnt", gnt, 4'b0010);
    lane_serial = 4'b1101;
    cyc();
    lane_serial = 4'b1111;
    cyc();
    lane_serial = 4'b1101;
    cyc();
    lane_serial = 4'b1101;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async", outs(), 28'd1);
    req = 4'b0000;
    cyc();
    cyc();
    rst_n = 1'b1;
    lane_serial = 4'b1111;
    seen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      seen = seen | rsp_valid | (|gnt);
    end
    chk("rst_no_rsp", seen, 1'b0);

    // Saturation: 255 checksum errors on lane 1, then one more
    for (int f = 0; f < 255; f++) begin
      req = 4'b0010;
      cyc();
      dec_error = 1'b1;
      cyc();
      dec_error = 1'b0;
      req       = 4'b0000;
      cyc();
    end
    chk("sat_reach", err_count, 8'd255);
    req = 4'b0010;
    cyc();
    dec_error = 1'b1;
    cyc();
    dec_error = 1'b0;
    req       = 4'b0000;
    chk("sat_hold", {rsp_valid, rsp_lane, rsp_status, err_count}, {1'b1, 2'd1, 2'd1, 8'd255});
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
